// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, one iteration per clock, with sign fix-up at the commit edge.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] acc_reg, q_reg, opnd_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             neg_q_reg, neg_r_reg, zero_div_reg, div0_reg;

  logic             accept, last_iter, busy, done;

  // op_i[0]=0 selects the signed variants (MULT, DIV); op_i[1]=1 selects divide
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [WIDTH-1:0] acc_step, q_step;

  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          last_iter  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        accept     = start_i;
        state_next = start_i ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & a_i[WIDTH-1];
    b_neg     = signed_op & b_i[WIDTH-1];
    a_mag     = a_neg ? -a_i : a_i;
    b_mag     = b_neg ? -b_i : b_i;
  end

  // acc holds the running high half (multiply) or partial remainder (divide);
  // q holds the shifting multiplier or the dividend turning into the quotient.
  always_comb begin
    addend    = q_reg[0] ? opnd_reg : {WIDTH{1'b0}};
    mul_sum   = {1'b0, acc_reg} + {1'b0, addend};
    div_trial = {acc_reg, q_reg[WIDTH-1]} - {1'b0, opnd_reg};
    if (op_reg[1]) begin
      if (!div_trial[WIDTH]) begin
        acc_step = div_trial[WIDTH-1:0];
        q_step   = {q_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {acc_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        q_step   = {q_reg[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = mul_sum[WIDTH:1];
      q_step   = {mul_sum[0], q_reg[WIDTH-1:1]};
    end
  end

  // Sign fix-up on the final iteration's outputs so the result commits in the same edge
  always_comb begin
    prod_mag = {acc_step, q_step};
    prod     = neg_q_reg ? -prod_mag : prod_mag;
    quot     = neg_q_reg ? -q_step : q_step;
    rem      = neg_r_reg ? -acc_step : acc_step;
    if (zero_div_reg) begin
      res_hi = {WIDTH{1'b0}};
      res_lo = {WIDTH{1'b0}};
    end else if (op_reg[1]) begin
      res_hi = rem;
      res_lo = quot;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      cnt_reg      <= '0;
      op_reg       <= '0;
      acc_reg      <= '0;
      q_reg        <= '0;
      opnd_reg     <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      zero_div_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div0_reg     <= 1'b0;
    end else begin
      if (accept) begin
        op_reg       <= op_i;
        cnt_reg      <= '0;
        acc_reg      <= '0;
        q_reg        <= op_i[1] ? a_mag : b_mag;
        opnd_reg     <= op_i[1] ? b_mag : a_mag;
        neg_q_reg    <= a_neg ^ b_neg;
        neg_r_reg    <= a_neg;
        zero_div_reg <= op_i[1] & (b_i == {WIDTH{1'b0}});
      end else if (busy) begin
        cnt_reg <= cnt_reg + 1'b1;
        acc_reg <= acc_step;
        q_reg   <= q_step;
      end
      // The commit edge lies in RUN, so MTHI/MTLO there lose to the result
      if (last_iter) begin
        hi_reg   <= res_hi;
        lo_reg   <= res_lo;
        div0_reg <= zero_div_reg;
      end else if (!busy) begin
        if (mthi_i) hi_reg <= wdata_i;
        if (mtlo_i) lo_reg <= wdata_i;
      end
    end
  end

  assign busy_o = busy;
  assign done_o = done;
  assign div0_o = div0_reg;
  assign hi_o   = hi_reg;
  assign lo_o   = lo_reg;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width; HI and LO are each WIDTH bits; legal values are even numbers 8..64.
REQ-002 Parameter CW, default $clog2(WIDTH): iteration counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset; asynchronous and active-high.
REQ-005 start_i  input  1  request to begin the operation selected by op_i.
REQ-006 op_i  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a_i  input  WIDTH  rs operand (multiplicand / dividend).
REQ-008 b_i  input  WIDTH  rt operand (multiplier / divisor).
REQ-009 mthi_i  input  1  write wdata_i to HI.
REQ-010 mtlo_i  input  1  write wdata_i to LO.
REQ-011 wdata_i  input  WIDTH  data for MTHI/MTLO.
REQ-012 busy_o  output  1  operation in progress.
REQ-013 done_o  output  1  one-cycle pulse when a result commits.
REQ-014 div0_o  output  1  sticky flag: the last completed operation was a divide by zero.
REQ-015 hi_o  output  WIDTH  HI register (MFHI source).
REQ-016 lo_o  output  WIDTH  LO register (MFLO source).

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE; busy_o=1 only in RUN; done_o=1 only in DONE.
REQ-018 start_i SHALL be accepted at a rising edge when state is IDLE or DONE; the edge latches op_i, a_i and b_i, clears the counter, and moves the FSM to RUN.
REQ-019 start_i in RUN SHALL be ignored (no queueing).
REQ-020 RUN SHALL perform one radix-2 iteration per cycle (shift-add multiply, restoring divide) on operand magnitudes.
REQ-021 After exactly WIDTH iterations, the FSM SHALL move to DONE, write hi_o/lo_o at that edge, and move to IDLE on the next edge unless start_i is accepted.
REQ-022 Latency: with acceptance at edge E0, hi_o/lo_o SHALL be valid and done_o SHALL be high in the cycle after edge E_WIDTH; busy_o SHALL be high between E0 and E_WIDTH.
REQ-023 MULT/MULTU: {hi,lo} SHALL hold the full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-024 Signed multiply: the core SHALL multiply magnitudes and negate the 2*WIDTH-bit product when the operand signs differ.
REQ-025 DIV/DIVU: lo SHALL hold the quotient and hi SHALL hold the remainder.
REQ-026 Signed divide: the quotient SHALL truncate toward zero and the remainder SHALL take the dividend's sign.
REQ-027 DIV of the most-negative value by -1 SHALL give lo = most-negative and hi = 0, with no flag.
REQ-028 Divide by zero (b=0, DIV or DIVU) SHALL keep the full latency, commit hi=0 and lo=0, and set div0_o=1.
REQ-029 Any other completed operation SHALL clear div0_o at the commit edge.
REQ-030 mthi_i/mtlo_i in IDLE or DONE SHALL write wdata_i to hi/lo at the edge; both asserted together SHALL write both.
REQ-031 mthi_i/mtlo_i in RUN SHALL be ignored.
REQ-032 If MT* and start_i occur at the same accepting edge, the MT* write SHALL take effect; the operation result later overwrites it.
REQ-033 If MT* occurs at the edge leaving RUN (the commit edge), the result SHALL win and the MT* write SHALL be ignored.
REQ-034 Operands latched at acceptance SHALL be used for the whole operation; later changes on a_i/b_i/op_i SHALL have no effect.

Reset
REQ-035 While reset_i=1, independent of clk, the block SHALL force state=IDLE, counter=0, hi_o=0, lo_o=0, busy_o=0, done_o=0 and div0_o=0.
REQ-036 Reset asserted mid-RUN SHALL abandon the operation with no partial commit.
REQ-037 The first start_i after reset deassertion SHALL be accepted normally at the next rising edge.

Verification
REQ-038 MULT, WIDTH=32, a=0xFFFFFFFE (-2), b=3 -> after 32 edges: done_o pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy_o high for exactly 32 cycles.
REQ-039 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-040 DIVU a=100, b=0 -> same latency, hi=lo=0, div0_o=1; next DIVU 100/7 -> lo=14, hi=2, div0_o=0.
REQ-041 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; start_i pulsed mid-RUN ignored; mthi_i mid-RUN leaves hi unchanged.
REQ-042 reset_i asserted asynchronously (between clock edges) at iteration 10 of a MULT -> immediately hi=lo=0, busy_o=0; no done_o pulse follows.
REQ-043 WIDTH=16: MULTU 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001 after 16 edges; back-to-back start_i in DONE -> accepted with no idle gap.
